// File: rtl/uart_rx.sv
// UART 8N1 receiver: two-flop synchronised input, mid-bit sampling, valid/ready output, sticky errors.
// Define UART_RX_FIFO_EN to replace the one-entry holding register with a FIFO_DEPTH-entry FIFO.
module uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uartRxPin,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frameError,
    output logic       overrun,
    input  logic       errClear
);

    localparam int            TW      = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST    = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shift, shift_next;
    logic          rx_meta, rxs;
    logic          push, ferr_set, pop, overrun_set;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uartRxPin;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_next = state;
        timer_next = timer;
        bit_next   = bit_idx;
        shift_next = shift;
        push       = 1'b0;
        ferr_set   = 1'b0;
        unique case (state)
            S_IDLE: begin
                timer_next = '0;
                if (!rxs) state_next = S_START;
            end
            S_START: begin
                if (timer == HALF_M1) begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    state_next = rxs ? S_IDLE : S_DATA;
                    timer_next = '0;
                    bit_next   = '0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            S_DATA: begin
                if (timer == LAST) begin
                    timer_next = '0;
                    shift_next = {rxs, shift[7:1]};
                    bit_next   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_next = S_STOP;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            S_STOP: begin
                if (timer == LAST) begin
                    timer_next = '0;
                    if (rxs) begin
                        push       = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = S_BREAK;
                    end
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            S_BREAK: begin
                timer_next = '0;
                if (rxs) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, accept;

    assign full        = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop         = (count != '0) && ready;
    assign accept      = push && (!full || pop);
    assign overrun_set = push && !accept;
    assign valid       = (count != '0);
    assign data        = valid ? mem[rd_ptr] : 8'h00;

    // NOTE: storage array has no reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
`else
    logic [7:0] hold_data;
    logic       hold_valid;

    assign pop         = hold_valid && ready;
    assign overrun_set = push && hold_valid && !pop;
    assign valid       = hold_valid;
    assign data        = hold_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_data  <= 8'h00;
            hold_valid <= 1'b0;
        end else if (push && (!hold_valid || pop)) begin
            hold_data  <= shift;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    // Sticky flags: a set in the same cycle as errClear wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            frameError <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frameError <= ferr_set | (frameError & ~errClear);
            overrun    <= overrun_set | (overrun & ~errClear);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with a byte scoreboard; also builds with UART_RX_FIFO_EN defined.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       uartRxPin = 1'b1;
    logic       ready = 1'b1;
    logic       errClear = 1'b0;
    logic [7:0] data;
    logic       valid, busy, frameError, overrun;

    int         n_checks = 0;
    int         n_fail = 0;
    int         hs_count = 0;
    int         ferr_rises = 0;
    int         hs0;
    logic       ferr_prev = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] b;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .uartRxPin (uartRxPin),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frameError(frameError),
        .overrun   (overrun),
        .errClear  (errClear)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic v);
        uartRxPin = v;
        wait_clks(CPB);
    endtask

    task automatic send_frame(input logic [7:0] byte_v, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(byte_v[i]);
        send_bit(stop_bit);
    endtask

    // Inputs change just after posedge, so the negedge view of valid&&ready is the handshake.
    always @(negedge clock) begin
        if (!reset && valid && ready) begin
            if (exp_q.size() == 0) check("unexpected_valid", 32'(valid), 32'd0);
            else                   check("rx_data", 32'(data), 32'(exp_q.pop_front()));
            hs_count++;
        end
        if (frameError && !ferr_prev) ferr_rises++;
        ferr_prev = frameError;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        wait_clks(3);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ferr", 32'(frameError), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        wait_clks(4);

        // Clean frame 0xA5 with busy timing around the start edge
        hs0 = hs_count;
        b = 8'hA5;
        exp_q.push_back(b);
        uartRxPin = 1'b0;
        wait_clks(1);
        check("busy_early", 32'(busy), 32'd0);
        wait_clks(2);
        check("busy_start", 32'(busy), 32'd1);
        wait_clks(CPB - 3);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(1'b1);
        wait_clks(4);
        check("a5_count", 32'(hs_count - hs0), 32'd1);
        check("a5_busy", 32'(busy), 32'd0);
        check("a5_ferr", 32'(frameError), 32'd0);

        // Short low glitch must be rejected at mid start bit
        hs0 = hs_count;
        uartRxPin = 1'b0;
        wait_clks(5);
        uartRxPin = 1'b1;
        for (int i = 0; i < 10 && busy; i++) wait_clks(1);
        check("glitch_busy", 32'(busy), 32'd0);
        wait_clks(CPB * 10);
        check("glitch_count", 32'(hs_count - hs0), 32'd0);
        check("glitch_ferr", 32'(frameError), 32'd0);
        check("glitch_ovr", 32'(overrun), 32'd0);

        // Bad stop bit followed by a held-low line
        hs0 = hs_count;
        send_frame(8'h3C, 1'b0);
        wait_clks(40);
        uartRxPin = 1'b1;
        wait_clks(20);
        check("brk_ferr", 32'(frameError), 32'd1);
        check("brk_events", 32'(ferr_rises), 32'd1);
        check("brk_count", 32'(hs_count - hs0), 32'd0);
        check("brk_busy", 32'(busy), 32'd0);
        errClear = 1'b1;
        wait_clks(1);
        errClear = 1'b0;
        check("clr_ferr", 32'(frameError), 32'd0);
        hs0 = hs_count;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        wait_clks(4);
        check("post_brk_count", 32'(hs_count - hs0), 32'd1);
        check("post_brk_ferr", 32'(frameError), 32'd0);

        // Back-pressure and overrun
        ready = 1'b0;
`ifdef UART_RX_FIFO_EN
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(8'(8'h10 + i));
            send_frame(8'(8'h10 + i), 1'b1);
            wait_clks(4);
            if (i == 3) check("fifo_ovr_before", 32'(overrun), 32'd0);
            check("fifo_head", 32'(data), 32'h10);
        end
        check("fifo_ovr", 32'(overrun), 32'd1);
        check("fifo_valid", 32'(valid), 32'd1);
        ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) wait_clks(1);
        wait_clks(2);
        check("fifo_drained", 32'(valid), 32'd0);
`else
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        wait_clks(4);
        check("hold_valid", 32'(valid), 32'd1);
        check("hold_data", 32'(data), 32'h01);
        send_frame(8'h02, 1'b1);
        wait_clks(4);
        check("ovr_data", 32'(data), 32'h01);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_valid", 32'(valid), 32'd1);
        ready = 1'b1;
        wait_clks(3);
        check("ovr_drained", 32'(valid), 32'd0);
`endif
        check("drain_queue", 32'(exp_q.size()), 32'd0);

        // Reset during DATA: remaining bits are all ones, so nothing restarts
        check("pre_rst_ovr", 32'(overrun), 32'd1);
        hs0 = hs_count;
        b = 8'hF0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        uartRxPin = 1'b1;
        wait_clks(8);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        wait_clks(1);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_data", 32'(data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ferr", 32'(frameError), 32'd0);
        check("mid_rst_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        wait_clks(CPB - 9);
        for (int i = 5; i < 8; i++) send_bit(b[i]);
        send_bit(1'b1);
        wait_clks(CPB * 2);
        check("abort_count", 32'(hs_count - hs0), 32'd0);
        check("abort_ferr", 32'(frameError), 32'd0);
        check("abort_ovr", 32'(overrun), 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_clks(4);
        check("final_count", 32'(hs_count - hs0), 32'd1);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
